// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage and IF/ID pipeline register.
//
// Holds the PC, drives the instruction-memory address, and registers
// {instr, PC+4, valid} for the decoder. Applies the hazard-unit stall,
// the ID-resolved redirect (branch/j/jal/jr) and the syscall-exit halt.
// There is no branch delay slot: a redirect squashes the wrong-path fetch.
//
// Ports:
//   clk            - clock, rising edge
//   rst_b          - asynchronous active-low reset
//   stall          - hold PC and IF/ID (load-use hazard)
//   redirect_valid - ID resolved a taken control transfer this cycle
//   redirect_pc    - redirect target; bits [1:0] are ignored
//   halt           - syscall exit decoded in ID; stop fetching for good
//   imem_addr      - instruction address (current PC)
//   imem_rdata     - instruction word read combinationally at imem_addr
//   if_id_instr    - registered instruction (32'h0 is a bubble)
//   if_id_pc4      - registered PC+4 of if_id_instr
//   if_id_valid    - if_id_instr is a real fetched instruction
//   halted         - stage has stopped after a halt
//   fetch_count    - valid instructions loaded into IF/ID (wraps)

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic             halt,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic {
        RUN,
        HALTED
    } state_e;

    state_e           state_q;
    logic [31:0]      pc_q;
    logic [31:0]      instr_q;
    logic [31:0]      pc4_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;

    logic [31:0]      pc4_d;
    logic [31:0]      tgt_d;

    // Natural 32-bit wrap gives FFFF_FFFC + 4 = 0.
    assign pc4_d = pc_q + 32'd4;

    // Word-align the target so the PC never leaves a word boundary.
    assign tgt_d = redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (halt) begin
                        state_q <= HALTED;
                        instr_q <= 32'h0;
                        pc4_q   <= 32'h0;
                        valid_q <= 1'b0;
                    end else if (redirect_valid) begin
                        // Redirect beats stall: the stalled
                        // instruction is on the wrong path anyway.
                        pc_q    <= tgt_d;
                        instr_q <= 32'h0;
                        pc4_q   <= 32'h0;
                        valid_q <= 1'b0;
                    end else if (!stall) begin
                        pc_q    <= pc4_d;
                        instr_q <= imem_rdata;
                        pc4_q   <= pc4_d;
                        valid_q <= 1'b1;
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign halted      = (state_q == HALTED);
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for if_stage.
// Instruction memory: RESET_PC holds 32'h2008_0005, else {16'h8C00, addr[15:0]}.

module tb_if_stage;

    logic        clk;
    logic        rst_b;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    int total;
    int bad;

    if_stage #(
        .RESET_PC(32'h0040_0000),
        .CNT_W   (32)
    ) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt          (halt),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_rdata = (imem_addr == 32'h0040_0000) ? 32'h2008_0005
                      : {16'h8C00, imem_addr[15:0]};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b1;
        tick();
        #2;
        rst_b = 1'b0;
        #1;
        total++;
        if (imem_addr !== 32'h0040_0000) begin
            bad++;
            $display("FAIL reset_addr: got %h expected 00400000", imem_addr);
        end
        total++;
        if ({if_id_instr, if_id_pc4} !== 64'h0) begin
            bad++;
            $display("FAIL reset_ifid: got %h/%h expected 0/0",
                     if_id_instr, if_id_pc4);
        end
        total++;
        if ({if_id_valid, halted} !== 2'b00) begin
            bad++;
            $display("FAIL reset_flags: got v=%b h=%b expected 0/0",
                     if_id_valid, halted);
        end
        total++;
        if (fetch_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_count: got %0d expected 0", fetch_count);
        end
        tick();
        rst_b = 1'b1;
    endtask

    task automatic test_fetch();
        tick();
        total++;
        if (if_id_instr !== 32'h2008_0005 || if_id_pc4 !== 32'h0040_0004) begin
            bad++;
            $display("FAIL fetch_ifid: got %h/%h expected 20080005/00400004",
                     if_id_instr, if_id_pc4);
        end
        total++;
        if (if_id_valid !== 1'b1 || fetch_count !== 32'd1) begin
            bad++;
            $display("FAIL fetch_vc: got v=%b c=%0d expected 1/1",
                     if_id_valid, fetch_count);
        end
        total++;
        if (imem_addr !== 32'h0040_0004) begin
            bad++;
            $display("FAIL fetch_addr: got %h expected 00400004", imem_addr);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (imem_addr !== 32'h0040_0004 || if_id_instr !== 32'h2008_0005
                || if_id_pc4 !== 32'h0040_0004 || if_id_valid !== 1'b1
                || fetch_count !== 32'd1) begin
                bad++;
                $display("FAIL stall_hold: got a=%h i=%h p=%h v=%b c=%0d expected 00400004/20080005/00400004/1/1",
                         imem_addr, if_id_instr, if_id_pc4, if_id_valid,
                         fetch_count);
            end
        end
        stall = 1'b0;
        tick();
        total++;
        if (if_id_instr !== 32'h8C00_0004 || if_id_pc4 !== 32'h0040_0008
            || fetch_count !== 32'd2 || imem_addr !== 32'h0040_0008) begin
            bad++;
            $display("FAIL stall_resume: got i=%h p=%h c=%0d a=%h expected 8c000004/00400008/2/00400008",
                     if_id_instr, if_id_pc4, fetch_count, imem_addr);
        end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0103;
        tick();
        redirect_valid = 1'b0;
        chk32("redir_addr", imem_addr, 32'h0040_0100);
        total++;
        if (if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b0
            || fetch_count !== 32'd2) begin
            bad++;
            $display("FAIL redir_bubble: got i=%h p=%h v=%b c=%0d expected 0/0/0/2",
                     if_id_instr, if_id_pc4, if_id_valid, fetch_count);
        end
        tick();
        total++;
        if (if_id_instr !== 32'h8C00_0100 || if_id_pc4 !== 32'h0040_0104
            || if_id_valid !== 1'b1 || fetch_count !== 32'd3) begin
            bad++;
            $display("FAIL redir_target: got i=%h p=%h v=%b c=%0d expected 8c000100/00400104/1/3",
                     if_id_instr, if_id_pc4, if_id_valid, fetch_count);
        end
    endtask

    task automatic test_stall_redirect();
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0200;
        tick();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        chk32("sr_addr", imem_addr, 32'h0040_0200);
        total++;
        if (if_id_instr !== 32'h0 || if_id_valid !== 1'b0
            || fetch_count !== 32'd3) begin
            bad++;
            $display("FAIL sr_bubble: got i=%h v=%b c=%0d expected 0/0/3",
                     if_id_instr, if_id_valid, fetch_count);
        end
    endtask

    task automatic test_halt();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0010;
        tick();
        // halt outranks a simultaneous redirect
        halt        = 1'b1;
        redirect_pc = 32'h0040_0500;
        tick();
        halt           = 1'b0;
        redirect_valid = 1'b0;
        total++;
        if (halted !== 1'b1 || imem_addr !== 32'h0040_0010
            || if_id_valid !== 1'b0) begin
            bad++;
            $display("FAIL halt_enter: got h=%b a=%h v=%b expected 1/00400010/0",
                     halted, imem_addr, if_id_valid);
        end
        redirect_valid = 1'b1;
        stall          = 1'b1;
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        tick();
        tick();
        total++;
        if (halted !== 1'b1 || imem_addr !== 32'h0040_0010
            || if_id_instr !== 32'h0 || if_id_valid !== 1'b0
            || fetch_count !== 32'd3) begin
            bad++;
            $display("FAIL halt_frozen: got h=%b a=%h i=%h v=%b c=%0d expected 1/00400010/0/0/3",
                     halted, imem_addr, if_id_instr, if_id_valid, fetch_count);
        end
        #2;
        rst_b = 1'b0;
        #1;
        total++;
        if (imem_addr !== 32'h0040_0000 || halted !== 1'b0
            || fetch_count !== 32'd0) begin
            bad++;
            $display("FAIL halt_reset: got a=%h h=%b c=%0d expected 00400000/0/0",
                     imem_addr, halted, fetch_count);
        end
        tick();
        rst_b = 1'b1;
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        chk32("wrap_align", imem_addr, 32'hFFFF_FFFC);
        tick();
        total++;
        if (if_id_pc4 !== 32'h0 || imem_addr !== 32'h0
            || if_id_instr !== 32'h8C00_FFFC || fetch_count !== 32'd1) begin
            bad++;
            $display("FAIL wrap_pc4: got p=%h a=%h i=%h c=%0d expected 0/0/8c00fffc/1",
                     if_id_pc4, imem_addr, if_id_instr, fetch_count);
        end
    endtask

    task automatic test_back_to_back();
        tick();
        total++;
        if (if_id_instr !== 32'h8C00_0000 || if_id_pc4 !== 32'h4
            || fetch_count !== 32'd2) begin
            bad++;
            $display("FAIL b2b_0: got i=%h p=%h c=%0d expected 8c000000/4/2",
                     if_id_instr, if_id_pc4, fetch_count);
        end
        tick();
        total++;
        if (if_id_instr !== 32'h8C00_0004 || if_id_pc4 !== 32'h8
            || fetch_count !== 32'd3 || imem_addr !== 32'h8) begin
            bad++;
            $display("FAIL b2b_1: got i=%h p=%h c=%0d a=%h expected 8c000004/8/3/8",
                     if_id_instr, if_id_pc4, fetch_count, imem_addr);
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst_b          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_stall_redirect();
        test_halt();
        test_wrap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
